// File: rtl/ultrasonic_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : ultrasonic_scheduler_if
// Description : Sensor pins and measurement results of the doorway scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface ultrasonic_scheduler_if #(
    parameter int CNT_W = 21
);
    logic             ENABLE;
    logic             ECHO1;
    logic             ECHO2;
    logic             TRIG1;
    logic             TRIG2;
    logic [CNT_W-1:0] echo_cycles;
    logic             sample_valid;
    logic             sample_sensor;
    logic             timeout;
    logic             present1;
    logic             present2;

    // master is the scheduler; slave is the sensor/direction-logic side
    modport master (
        input  ENABLE, ECHO1, ECHO2,
        output TRIG1, TRIG2, echo_cycles, sample_valid, sample_sensor,
               timeout, present1, present2
    );

    modport slave (
        output ENABLE, ECHO1, ECHO2,
        input  TRIG1, TRIG2, echo_cycles, sample_valid, sample_sensor,
               timeout, present1, present2
    );
endinterface
`default_nettype wire

// File: rtl/ultrasonic_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ultrasonic_scheduler
// Description : Alternating trigger/echo controller for two ultrasonic sensors.
// Revision    : 1.0 - initial release
// ============================================================================
module ultrasonic_scheduler #(
    parameter int TRIG_CYCLES         = 500,
    parameter int ECHO_TIMEOUT_CYCLES = 1_500_000,
    parameter int GUARD_CYCLES        = 50_000,
    parameter int THRESH_CYCLES       = 145_000,
    parameter int CNT_W               = 21
) (
    input  wire logic              CLOCK_50,
    input  wire logic              RESET_N,
    ultrasonic_scheduler_if.master bus
);

    localparam logic [CNT_W-1:0] c_trig_last    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(ECHO_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout      = CNT_W'(ECHO_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_guard        = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] c_thresh       = CNT_W'(THRESH_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_GUARD     = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_sel;
    logic             w_sel_next;
    logic             w_publish;
    logic             w_tmo;
    logic             w_trig_next;
    logic             w_near;

    logic r_e1_meta, r_e1s, r_e1_prev;
    logic r_e2_meta, r_e2s, r_e2_prev;
    logic w_es, w_ep, w_rise, w_fall;

    logic             r_trig1;
    logic             r_trig2;
    logic [CNT_W-1:0] r_echo_cycles;
    logic             r_sample_valid;
    logic             r_sample_sensor;
    logic             r_timeout;
    logic             r_present1;
    logic             r_present2;

    // Only the active sensor's synchronized echo is ever looked at
    assign w_es      = r_sel ? r_e2s     : r_e1s;
    assign w_ep      = r_sel ? r_e2_prev : r_e1_prev;
    assign w_rise    = w_es & ~w_ep;
    assign w_fall    = ~w_es & w_ep;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // The rise cycle itself was already high when MEASURE starts at zero
    assign w_near    = (w_cnt_inc < c_thresh);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_e1_meta <= 1'b0;
            r_e1s     <= 1'b0;
            r_e1_prev <= 1'b0;
            r_e2_meta <= 1'b0;
            r_e2s     <= 1'b0;
            r_e2_prev <= 1'b0;
        end else begin
            r_e1_meta <= bus.ECHO1;
            r_e1s     <= r_e1_meta;
            r_e1_prev <= r_e1s;
            r_e2_meta <= bus.ECHO2;
            r_e2s     <= r_e2_meta;
            r_e2_prev <= r_e2s;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_sel   <= w_sel_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_sel_next   = r_sel;
        w_publish    = 1'b0;
        w_tmo        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ENABLE) begin
                    w_state_next = S_TRIG;
                    w_cnt_next   = '0;
                end
            end
            S_TRIG: begin
                if (r_cnt == c_trig_last) begin
                    w_state_next = S_WAIT_RISE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            S_WAIT_RISE: begin
                if (w_rise) begin
                    w_state_next = S_MEASURE;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_timeout_last) begin
                    w_tmo        = 1'b1;
                    w_state_next = S_GUARD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            S_MEASURE: begin
                if (w_fall) begin
                    w_publish    = 1'b1;
                    w_state_next = S_GUARD;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_timeout_last) begin
                    w_tmo        = 1'b1;
                    w_state_next = S_GUARD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            S_GUARD: begin
                if (r_cnt == c_guard) begin
                    w_sel_next   = ~r_sel;
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign w_trig_next = (w_state_next == S_TRIG);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_trig1         <= 1'b0;
            r_trig2         <= 1'b0;
            r_echo_cycles   <= '0;
            r_sample_valid  <= 1'b0;
            r_sample_sensor <= 1'b0;
            r_timeout       <= 1'b0;
            r_present1      <= 1'b0;
            r_present2      <= 1'b0;
        end else begin
            r_trig1        <= w_trig_next & ~w_sel_next;
            r_trig2        <= w_trig_next & w_sel_next;
            r_sample_valid <= w_publish | w_tmo;
            r_timeout      <= w_tmo;
            if (w_publish || w_tmo) begin
                r_echo_cycles   <= w_publish ? w_cnt_inc : c_timeout;
                r_sample_sensor <= r_sel;
                if (r_sel) begin
                    r_present2 <= w_publish & w_near;
                end else begin
                    r_present1 <= w_publish & w_near;
                end
            end
        end
    end

    assign bus.TRIG1         = r_trig1;
    assign bus.TRIG2         = r_trig2;
    assign bus.echo_cycles   = r_echo_cycles;
    assign bus.sample_valid  = r_sample_valid;
    assign bus.sample_sensor = r_sample_sensor;
    assign bus.timeout       = r_timeout;
    assign bus.present1      = r_present1;
    assign bus.present2      = r_present2;

endmodule
`default_nettype wire

// File: doc/ultrasonic_scheduler.md
# ultrasonic_scheduler

Time-multiplexed trigger/echo controller for the two ultrasonic sensors at the crowd-control doorway. It fires TRIG1 and TRIG2 in strict alternation so the sensors never ring simultaneously, then measures each echo pulse width in clock cycles and flags a per-sensor "person present" state. Its outputs feed the entry/exit direction logic, which turns present1-then-present2 into an entry and present2-then-present1 into an exit.

## Interface
- TRIG_CYCLES, 500, TRIG pulse width in clocks (10 µs at 50 MHz)
- ECHO_TIMEOUT_CYCLES, 1_500_000, max wait for echo rise, and max echo width (30 ms)
- GUARD_CYCLES, 50_000, dead time after each measurement before the other sensor fires (1 ms)
- THRESH_CYCLES, 145_000, presence threshold; echo shorter than this means a person is present (~50 cm)
- CNT_W, 21, width of echo counter and echo_cycles; must hold ECHO_TIMEOUT_CYCLES
- CLOCK_50 in 1, system clock, 50 MHz
- RESET_N in 1, asynchronous active-low reset
- ENABLE in 1, run scheduling; sampled only in IDLE
- ECHO1 in 1, sensor 1 echo, asynchronous
- ECHO2 in 1, sensor 2 echo, asynchronous
- TRIG1 out 1, sensor 1 trigger, registered
- TRIG2 out 1, sensor 2 trigger, registered
- echo_cycles out CNT_W, last measured width, saturated at ECHO_TIMEOUT_CYCLES
- sample_valid out 1, one-cycle strobe; echo_cycles and sample_sensor are valid
- sample_sensor out 1, 0 = sensor 1, 1 = sensor 2
- timeout out 1, one-cycle strobe coincident with sample_valid on timeout
- present1 out 1, sensor 1 presence, level
- present2 out 1, sensor 2 presence, level

## Operation
- ECHO1 and ECHO2 each pass through a 2-flop synchronizer. All echo logic uses the synchronized versions (e1s, e2s) plus a previous-value register for edge detection.
- `sel` register picks the active sensor: 0 = sensor 1. It resets to 0 and toggles on each exit from GUARD.
- FSM states:
  - IDLE: if ENABLE, go to TRIG.
  - TRIG: drive TRIG[sel] high for TRIG_CYCLES clocks, then go to WAIT_RISE and clear the counter.
  - WAIT_RISE: count. On a rising edge of the active synchronized echo, clear the counter and go to MEASURE. If the count reaches ECHO_TIMEOUT_CYCLES, declare a timeout.
  - MEASURE: count while the echo is high. On the falling edge, publish the sample. If the count reaches ECHO_TIMEOUT_CYCLES, declare a timeout.
  - GUARD: count to GUARD_CYCLES, toggle sel, go to IDLE.
- Publish on a normal falling edge:
  - echo_cycles = number of cycles the synchronized echo was high.
  - sample_valid=1 and sample_sensor=sel for one cycle.
  - present[sel] = (echo_cycles < THRESH_CYCLES).
  - Then go to GUARD.
- Timeout:
  - echo_cycles = ECHO_TIMEOUT_CYCLES, with sample_valid=1 and timeout=1 for one cycle.
  - present[sel] is cleared, then go to GUARD.
- An echo stuck high from before the trigger produces no rising edge, so it times out.
- The inactive sensor's echo is ignored entirely. Its present flag holds.
- If ENABLE drops mid-cycle, the current measurement and guard complete, then the FSM parks in IDLE. All outputs hold.
- Counter arithmetic is unsigned CNT_W and never wraps, because comparisons cap it at the timeout value.

## Timing
- Reset values: TRIG1=TRIG2=0, echo_cycles=0, sample_valid=0, sample_sensor=0, timeout=0, present1=present2=0, FSM=IDLE, sel=0.
- Reset is asynchronous, so TRIG falls immediately even if asserted mid-pulse.
- TRIG rises on the clock edge after IDLE is left with ENABLE=1. It stays high exactly TRIG_CYCLES cycles. At most one TRIG is high at any time.
- Pin-to-detection latency is 3 clocks (2 synchronizer stages plus 1 edge register).
- sample_valid asserts the clock after the synchronized falling edge is detected. present updates on that same edge.
- Measured width equals the raw pin high time in cycles, ±1 from synchronizer quantization.
- Timeout strobe fires exactly ECHO_TIMEOUT_CYCLES cycles after entering WAIT_RISE or MEASURE.
- The next TRIG rises GUARD_CYCLES + 2 cycles after sample_valid.

## Test plan
All scenarios use TRIG_CYCLES=4, ECHO_TIMEOUT_CYCLES=1000, GUARD_CYCLES=20, THRESH_CYCLES=100.

- **Reset and alternation:** release RESET_N with ENABLE=1 and return 50-cycle echoes. Required: TRIG1 high 4 cycles; echo_cycles=50±1, sample_sensor=0; then TRIG2 fires; TRIG1 and TRIG2 are never both high.
- **Presence threshold:** ECHO1 width 60, then ECHO2 width 300. Required: present1=1, present2=0. A later ECHO1 width 150 clears present1.
- **No echo:** hold ECHO1 low. Required: timeout=1 and sample_valid=1 exactly 1000 cycles after WAIT_RISE entry; echo_cycles=1000; present1=0; next TRIG2 follows.
- **Stuck/over-long echo:** ECHO2 high from before TRIG2, or a 5000-cycle pulse. Required: timeout, echo_cycles=1000, present2=0, no counter wrap.
- **Crosstalk and simultaneous echoes:** pulse ECHO2 while sensor 1 is active, with ECHO1 and ECHO2 rising together. Required: only ECHO1 is measured and present2 is unchanged.
- **Reset and ENABLE mid-operation:**
  - Assert RESET_N low during TRIG1 high. Required: TRIG1=0 immediately and all outputs at reset values.
  - Drop ENABLE during MEASURE. Required: the sample still publishes, then no further TRIG.
